// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for a VGA-style display.
// A clock divider produces a one-clk pixelTick every CLK_DIV clocks. On each
// tick the pixel/line counters advance. bright, hSync and vSync are computed
// from the next-count values, so they change on the same edge as the counters.
// Ports:
//   clk        system clock (the only clock)
//   rst_n      asynchronous active-low reset
//   pixelTick  one-clk pulse; counters advance on the edge that ends it
//   hCount     horizontal pixel index, 0..H_TOTAL-1
//   vCount     vertical line index, 0..V_TOTAL-1
//   bright     high inside the active region
//   hSync      horizontal sync, asserted level = SYNC_POL
//   vSync      vertical sync, asserted level = SYNC_POL
//   frameStart one-clk pulse when the counters load (0,0)
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pixelTick,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       frameStart
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  // With no division the tick is permanently high, including through reset.
  localparam logic TICK_RESET = (CLK_DIV == 1) ? 1'b1 : 1'b0;

  logic [DIV_W-1:0] divCount;
  logic [DIV_W-1:0] divNext;
  logic             tickNext;
  logic [CNT_W-1:0] hNext;
  logic [CNT_W-1:0] vNext;
  logic             brightNext;
  logic             hSyncNext;
  logic             vSyncNext;
  logic             frameStartNext;

  // Divider: counts 0..CLK_DIV-1; tick is registered from the next divider value.
  always_comb begin
    divNext  = '0;
    tickNext = 1'b0;
    if (divCount != DIV_LAST) begin
      divNext = divCount + DIV_W'(1);
    end
    tickNext = (divNext == DIV_LAST);
  end

  // Counter advance and next-value decode of the timing outputs.
  always_comb begin
    hNext          = hCount;
    vNext          = vCount;
    brightNext     = bright;
    hSyncNext      = hSync;
    vSyncNext      = vSync;
    frameStartNext = 1'b0;
    if (pixelTick) begin
      if (hCount == H_LAST) begin
        hNext = '0;
        if (vCount == V_LAST) begin
          vNext = '0;
        end else begin
          vNext = vCount + CNT_W'(1);
        end
      end else begin
        hNext = hCount + CNT_W'(1);
      end
      brightNext = (hNext < CNT_W'(H_ACTIVE)) && (vNext < CNT_W'(V_ACTIVE));
      hSyncNext  = ((hNext >= CNT_W'(H_SYNC_START)) && (hNext < CNT_W'(H_SYNC_END)))
                   ? SYNC_POL : ~SYNC_POL;
      vSyncNext  = ((vNext >= CNT_W'(V_SYNC_START)) && (vNext < CNT_W'(V_SYNC_END)))
                   ? SYNC_POL : ~SYNC_POL;
      frameStartNext = (hNext == '0) && (vNext == '0);
    end
  end

  // Reset parks the counters on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCount   <= '0;
      pixelTick  <= TICK_RESET;
      hCount     <= H_LAST;
      vCount     <= V_LAST;
      bright     <= 1'b0;
      hSync      <= ~SYNC_POL;
      vSync      <= ~SYNC_POL;
      frameStart <= 1'b0;
    end else begin
      divCount   <= divNext;
      pixelTick  <= tickNext;
      hCount     <= hNext;
      vCount     <= vNext;
      bright     <= brightNext;
      hSync      <= hSyncNext;
      vSync      <= vSyncNext;
      frameStart <= frameStartNext;
    end
  end

endmodule
